// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: drain FSM encoding and width helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int RES_W(input int d_w);
    return 2 * d_w;
  endfunction

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Result stream leaving the drain stage: data tagged with column and arrival index.
interface systolic_drain_if import systolic_pkg::*; #(
  parameter int D_W = 8,
  parameter int N   = 4,
  parameter int M   = 4
) ();

  logic [RES_W(D_W)-1:0] m_data;
  logic [idx_w(N)-1:0]   m_col;
  logic [idx_w(M)-1:0]   m_idx;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, m_col, m_idx, m_valid, input m_ready);
  modport slave  (input m_data, m_col, m_idx, m_valid, output m_ready);

endinterface

// File: rtl/drain_fifo.sv
// Per-column synchronous FIFO; a push into a full FIFO is taken only when it pops in the same cycle.
module drain_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/systolic_drain.sv
// Captures the non-stallable column drain streams into FIFOs and re-emits one tile
// as a single column-major ready/valid stream.
module systolic_drain import systolic_pkg::*; #(
  parameter int D_W   = 8,
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N*RES_W(D_W)-1:0]   col_data,
  input  logic [N-1:0]              col_valid,
  systolic_drain_if.master          m,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      stray
);

  localparam int RW = RES_W(D_W);
  localparam int CW = idx_w(N);
  localparam int KW = idx_w(M);

  state_t         state, state_nxt;
  logic [CW-1:0]  cc;
  logic [KW-1:0]  kk;
  logic [N-1:0]   push, pop, empty, full;
  logic [RW-1:0]  head [N];
  logic           arm, fire, kk_wrap, last;

  assign arm     = (state == IDLE) && start;
  assign fire    = m.m_valid && m.m_ready;
  assign kk_wrap = (kk == KW'(M-1));
  assign last    = kk_wrap && (cc == CW'(N-1));
  assign push    = (state == DRAIN) ? col_valid : '0;

  for (genvar c = 0; c < N; c++) begin : g_col
    assign pop[c] = fire && (cc == CW'(c));

    drain_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .data  (col_data[c*RW +: RW]),
      .pop   (pop[c]),
      .flush (arm),
      .head  (head[c]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRAIN;
      DRAIN:   if (fire && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      cc <= '0;
      kk <= '0;
    end else if (fire) begin
      if (kk_wrap) begin
        kk <= '0;
        cc <= (cc == CW'(N-1)) ? '0 : cc + 1'b1;
      end else begin
        kk <= kk + 1'b1;
      end
    end
  end

  // A word is lost only if its FIFO is full and not draining in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      overflow <= 1'b0;
      stray    <= 1'b0;
    end else begin
      overflow <= overflow | (|(push & full & ~pop));
      stray    <= stray | ((state != DRAIN) && (|col_valid));
    end
  end

  always_comb begin
    m.m_valid = (state == DRAIN) && !empty[cc];
    m.m_data  = m.m_valid ? head[cc] : '0;
    m.m_col   = cc;
    m.m_idx   = kk;
    busy      = (state == DRAIN);
    done      = (state == DONE);
  end

endmodule
